// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over a valid/ready request channel,
// buffers in-order responses in a small slot ring and presents them to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_slot_pc    [DEPTH];
    logic [31:0]      r_slot_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PW-1:0]    r_alloc;
    logic [PW-1:0]    r_fill;
    logic [PW-1:0]    r_head;
    logic [CW-1:0]    r_used;
    logic [CW-1:0]    r_infl;
    logic [CW-1:0]    r_drop_cnt;
    logic             r_id_valid;
    logic [31:0]      r_id_instr;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_pc_plus4;

    logic             w_accept;
    logic             w_rsp_keep;
    logic             w_rsp_drop;
    logic             w_pop;
    logic [PW-1:0]    w_head_nxt;
    logic [CW-1:0]    w_drop_nxt;
    logic [31:0]      w_redirect_pc;
    logic             w_id_valid_nxt;
    logic [31:0]      w_id_instr_nxt;
    logic [31:0]      w_id_pc_nxt;

    assign w_redirect_pc = redirect_pc & ~32'd3;
    assign w_accept      = imem_req_valid && imem_req_ready;
    assign w_rsp_drop    = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep    = imem_rsp_valid && (r_drop_cnt == '0) && (r_infl != '0);
    assign w_pop         = r_id_valid && id_ready;
    assign w_head_nxt    = r_head + PW'(w_pop);

    // Fetches still outstanding at a redirect (including one accepted that cycle) become drops.
    always_comb begin
        w_drop_nxt = r_drop_cnt - CW'(w_rsp_drop);
        if (redirect_valid) begin
            w_drop_nxt = w_drop_nxt + r_infl + CW'(w_accept) - CW'(w_rsp_keep);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem_req_valid = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   imem_req_valid = (r_used != CW'(DEPTH));
            S_DRAIN: if (w_drop_nxt == '0) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
        if (redirect_valid) begin
            w_state_nxt = (w_drop_nxt != '0) ? S_DRAIN : S_RUN;
        end
    end

    assign imem_req_addr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_filled   <= '0;
            r_alloc    <= '0;
            r_fill     <= '0;
            r_head     <= '0;
            r_used     <= '0;
            r_infl     <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_drop_cnt <= w_drop_nxt;
            if (redirect_valid) begin
                r_pc     <= w_redirect_pc;
                r_filled <= '0;
                r_alloc  <= '0;
                r_fill   <= '0;
                r_head   <= '0;
                r_used   <= '0;
                r_infl   <= '0;
            end else begin
                if (w_accept) begin
                    r_pc    <= r_pc + 32'd4;
                    r_alloc <= r_alloc + PW'(1);
                end
                if (w_rsp_keep) begin
                    r_filled[r_fill] <= 1'b1;
                    r_fill           <= r_fill + PW'(1);
                end
                if (w_pop) begin
                    r_filled[r_head] <= 1'b0;
                    r_head           <= w_head_nxt;
                end
                r_used <= r_used + CW'(w_accept) - CW'(w_pop);
                r_infl <= r_infl + CW'(w_accept) - CW'(w_rsp_keep);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && !redirect_valid) begin
            r_slot_pc[r_alloc] <= r_pc;
        end
        if (w_rsp_keep && !redirect_valid) begin
            r_slot_instr[r_fill] <= imem_rsp_data;
        end
    end

    // Output register mirrors the head slot as it will be after this edge, bypassing a fill into it.
    always_comb begin
        w_id_valid_nxt = r_filled[w_head_nxt];
        w_id_instr_nxt = r_slot_instr[w_head_nxt];
        w_id_pc_nxt    = r_slot_pc[w_head_nxt];
        if (w_rsp_keep && (r_fill == w_head_nxt)) begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = imem_rsp_data;
        end
        if (redirect_valid) begin
            w_id_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= 32'd0;
            r_id_pc       <= RESET_PC;
            r_id_pc_plus4 <= RESET_PC + 32'd4;
        end else begin
            r_id_valid <= w_id_valid_nxt;
            if (w_id_valid_nxt) begin
                r_id_instr    <= w_id_instr_nxt;
                r_id_pc       <= w_id_pc_nxt;
                r_id_pc_plus4 <= w_id_pc_nxt + 32'd4;
            end
        end
    end

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

`ifndef SYNTHESIS
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((r_drop_cnt != '0) || (r_infl != '0)))
        else $error("fetch_unit: response arrived with no fetch in flight");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a reset-during-drain sequence,
// with a fixed-latency in-order memory whose word at address a is a ^ 32'hDEAD_0000.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    int mcyc   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: a request accepted at one edge answers lat cycles later, one response per cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    initial begin
        bit          acc;
        bit          rsp;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            acc = rst_n && imem_req_valid && imem_req_ready;
            a   = imem_req_addr;
            rsp = imem_rsp_valid;
            @(posedge clk);
            #1;
            mcyc++;
            if (!rst_n) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'd0;
            end else begin
                if (rsp && mq.size() > 0) void'(mq.pop_front());
                if (acc) mq.push_back('{addr: a, due: mcyc + lat - 1});
                if (mq.size() > 0 && mq[0].due <= mcyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mq[0].addr ^ KEY;
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 32'd0;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, ".req_addr"},  imem_req_addr,       32'h0000_0000);
        chk({tag, ".id_valid"},  32'(id_valid),       32'd0);
        chk({tag, ".id_instr"},  id_instr,            32'd0);
        chk({tag, ".id_pc"},     id_pc,               32'h0000_0000);
        chk({tag, ".id_pc4"},    id_pc_plus4,         32'h0000_0004);
    endtask

    // Holds reset for two cycles, checks the reset outputs, releases just after an edge.
    task automatic do_reset(input int l, input string tag);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs(tag);
        lat   = l;
        rst_n = 1'b1;
    endtask

    // Called just after an edge: drive one cycle of inputs, check at the falling edge.
    task automatic step(input int rdy, input int redir, input logic [31:0] rpc,
                        input int e_req, input logic [31:0] e_addr,
                        input int e_idv, input logic [31:0] e_pc, input string tag);
        id_ready       = (rdy != 0);
        redirect_valid = (redir != 0);
        redirect_pc    = rpc;
        @(negedge clk);
        chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(e_req));
        if (e_req != 0) chk({tag, ".req_addr"}, imem_req_addr, e_addr);
        chk({tag, ".id_valid"}, 32'(id_valid), 32'(e_idv));
        if (e_idv != 0) begin
            chk({tag, ".id_pc"},    id_pc,       e_pc);
            chk({tag, ".id_instr"}, id_instr,    e_pc ^ KEY);
            chk({tag, ".id_pc4"},   id_pc_plus4, e_pc + 32'd4);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          lat;    // >0: reset with this memory latency before the vector
        int          n;      // repeat count
        int          rdy;
        int          redir;
        logic [31:0] rpc;
        int          e_req;
        logic [31:0] e_addr;
        int          e_idv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vt[$];

    initial begin
        // T1: 1-cycle memory, decode always ready
        vt.push_back('{1, 1, 1, 0, 32'h0, 0, 32'h0,  0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'h0,  0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'h4,  0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0, 0, 32'h0,  1, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'h8,  1, 32'h4});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'hC,  0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0, 0, 32'h0,  1, 32'h8});
        // T2: decode stalls for 10 cycles, then drains
        vt.push_back('{0, 1, 0, 0, 32'h0, 1, 32'h10, 1, 32'hC});
        vt.push_back('{0, 9, 0, 0, 32'h0, 0, 32'h0,  1, 32'hC});
        vt.push_back('{0, 1, 1, 0, 32'h0, 0, 32'h0,  1, 32'hC});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'h14, 1, 32'h10});
        vt.push_back('{0, 1, 1, 0, 32'h0, 1, 32'h18, 0, 32'h0});
        // T3: 3-cycle memory, redirect to 0x103 with two fetches in flight
        vt.push_back('{3, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h103, 0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 2, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0});
        vt.push_back('{0, 2, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h100});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104});
        // T4: redirect in the same cycle as an accept and a response
        vt.push_back('{1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 1, 32'h200, 1, 32'h4,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,   0, 32'h0,   1, 32'h200});
        vt.push_back('{0, 1, 1, 0, 32'h0,   1, 32'h208, 1, 32'h204});
        // T5: PC wrap at the top of the address space
        vt.push_back('{1, 1, 1, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0});
        vt.push_back('{0, 1, 1, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC});
        vt.push_back('{0, 1, 1, 0, 32'h0,         1, 32'h4,         1, 32'h0});

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].lat > 0) do_reset(vt[i].lat, $sformatf("rst_v%0d", i));
            for (int k = 0; k < vt[i].n; k++) begin
                step(vt[i].rdy, vt[i].redir, vt[i].rpc, vt[i].e_req, vt[i].e_addr,
                     vt[i].e_idv, vt[i].e_pc, $sformatf("v%0d.%0d", i, k));
            end
        end

        // T6: reset asserted while draining two dropped fetches
        do_reset(2, "t6_pre");
        step(1, 0, 32'h0,  0, 32'h0, 0, 32'h0, "t6.c0");
        step(1, 0, 32'h0,  1, 32'h0, 0, 32'h0, "t6.c1");
        step(1, 0, 32'h0,  1, 32'h4, 0, 32'h0, "t6.c2");
        step(1, 0, 32'h0,  0, 32'h0, 0, 32'h0, "t6.c3");
        step(1, 0, 32'h0,  0, 32'h0, 1, 32'h0, "t6.c4");
        step(1, 0, 32'h0,  1, 32'h8, 1, 32'h4, "t6.c5");
        step(1, 1, 32'h40, 1, 32'hC, 0, 32'h0, "t6.c6");
        step(1, 0, 32'h0,  0, 32'h0, 0, 32'h0, "t6.c7");
        chk("t6.hold_pc",    id_pc,       32'h4);
        chk("t6.hold_pc4",   id_pc_plus4, 32'h8);
        chk("t6.hold_instr", id_instr,    32'h4 ^ KEY);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        do_reset(1, "t6_hold");
        step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, "t6.r0");
        step(1, 0, 32'h0, 1, 32'h0, 0, 32'h0, "t6.r1");
        step(1, 0, 32'h0, 1, 32'h4, 0, 32'h0, "t6.r2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
